rr_arb_requester: RTL
=====================

# rr_arb_requester

Requester-side front end for the 4-way round-robin arbiter. Each client pushes jobs as single-cycle pulses; the block queues them per client, drives the level-sensitive `req` vector into the arbiter, watches the returned one-hot `grant`, holds ownership for a fixed burst of beats, and then drops `req` for one cycle so the arbiter can rotate. It also flags protocol violations on the grant side.

## Interface
- `N`, 4, number of clients; must match the arbiter width.
- `MAX_PEND`, 7, maximum queued jobs per client; pending counter width is $clog2(MAX_PEND+1).
- `BURST_LEN`, 4, beats per granted tenure; must be ≥1.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `job_push`  in  N  per-client one-cycle job submit.
- `job_ready`  out  N  client may push (pending < MAX_PEND).
- `req`  out  N  request to arbiter; registered.
- `grant`  in  N  grant from arbiter; legal values are one-hot or zero.
- `beat_valid`  out  N  client i owns the resource this cycle; registered.
- `done`  out  N  one-cycle pulse on the last beat of a tenure.
- `err_grant`  out  1  sticky: grant seen on a non-requesting client, or grant not one-hot/zero.
- `err_overflow`  out  1  sticky: push while `job_ready` was low.

## Operation
- Per-client FSM, states IDLE, REQ, OWN, REL:
  - IDLE: `req`=0. Moves to REQ when pending > 0.
  - REQ: `req`=1. Samples `grant[i]`=1 → OWN, with beat counter cleared.
  - OWN: `req`=1 and `beat_valid`=1. Beat counter increments each cycle. On beat BURST_LEN-1, `done`=1, pending decrements, and the FSM moves to REL.
  - REL: `req`=0 for exactly one cycle. Then REQ if pending > 0, else IDLE.
- Grant loss: if `grant[i]` drops during OWN before the last beat, the tenure is aborted.
  - Beat counter clears, pending is unchanged, no `done`, FSM → REL.
- Pending counter:
  - Push alone → +1; completion alone → −1; both in the same cycle → unchanged.
  - Push when pending == MAX_PEND is dropped and sets `err_overflow`.
- Grant checking:
  - Non-one-hot, non-zero `grant` is treated as all-zero for FSM purposes and sets `err_grant`.
  - `grant[i]`=1 while client i is in IDLE or REL is ignored and sets `err_grant`.
- Error flags clear only on reset.
- Reset values: `req`=0, `beat_valid`=0, `done`=0, `err_*`=0, `job_ready`=all ones, all FSMs IDLE, pending=0, beat counters=0.
- Reset asserted mid-tenure drops everything immediately (asynchronous). Queued jobs are lost.

## Timing
- Push at edge t → pending updates at t+1 → `req` high from t+2 (FSM leaves IDLE at t+1 edge, registered output).
- `grant[i]` high at edge g while in REQ → `beat_valid[i]` high for cycles g+1 … g+BURST_LEN, with `done[i]` on cycle g+BURST_LEN.
- `req[i]` low for the single cycle after the last beat (REL), then high again if work remains.
- Minimum spacing between tenures of one client is BURST_LEN+2 cycles.
- `job_ready` is combinational from the registered pending count and reflects the value before this cycle's push.

## Structure
- Package `rr_arb_pkg`: client state enum (IDLE, REQ, OWN, REL), default `N`/`MAX_PEND`/`BURST_LEN` constants, and a one-hot check function.
- Sub-module `rr_arb_client`: one FSM, pending counter and beat counter. Instantiated N times in a generate loop.
- Top level holds the one-hot check, the error flags and the port vectors.

## Test plan
- Reset check: during and after reset all outputs hold their reset values.
- Single job: push client 0 at cycle 2, arbiter model grants at cycle 5.
  - Required: `beat_valid[0]` high for cycles 6–9, `done[0]` at 9, `req[0]` low at 10, then IDLE.
- Back-to-back: push client 2 three times, then hold `grant` = 0100 continuously.
  - Required: three tenures of 4 beats, each separated by one REL cycle, with pending stepping 3→2→1→0.
- Overflow: 8 pushes to client 1 with no grant.
  - Required: pending saturates at 7, `job_ready[1]`=0, `err_overflow`=1.
  - Then one push together with one completion leaves pending at 7.
- Grant abort: grant client 3, drop `grant` after 2 beats.
  - Required: no `done`, pending unchanged, REL for one cycle, then REQ.
- Bad grant: drive `grant`=0011, and separately `grant`=1000 with client 3 idle.
  - Required: `err_grant`=1 and no FSM advances.

Source files
------------

// File: rtl/rr_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arb_pkg                                                                 |
// | Shared types, defaults and helpers for the round-robin requester front end.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package rr_arb_pkg;

  localparam int DEF_N         = 4;
  localparam int DEF_MAX_PEND  = 7;
  localparam int DEF_BURST_LEN = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_OWN  = 2'd2,
    ST_REL  = 2'd3
  } client_state_t;

  // True when at most one bit is set; callers zero-extend narrower vectors.
  function automatic logic is_onehot0(input logic [31:0] v);
    return (v & (v - 32'd1)) == 32'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb_requester_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arb_requester_if                                                        |
// | Client job push, arbiter req/grant and ownership status bundle.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface rr_arb_requester_if
  import rr_arb_pkg::*;
#(
  parameter int N = DEF_N
) ();

  logic [N-1:0] job_push;
  logic [N-1:0] job_ready;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [N-1:0] beat_valid;
  logic [N-1:0] done;
  logic         err_grant;
  logic         err_overflow;

  // Environment side: clients pushing jobs and the arbiter returning grants.
  modport master (
    output job_push,
    output grant,
    input  job_ready,
    input  req,
    input  beat_valid,
    input  done,
    input  err_grant,
    input  err_overflow
  );

  modport slave (
    input  job_push,
    input  grant,
    output job_ready,
    output req,
    output beat_valid,
    output done,
    output err_grant,
    output err_overflow
  );

endinterface
`default_nettype wire

// File: rtl/rr_arb_client.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arb_client                                                              |
// | One requester: job queue counter, request/own/release FSM, beat counter.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rr_arb_client
  import rr_arb_pkg::*;
#(
  parameter int MAX_PEND  = DEF_MAX_PEND,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  wire logic clk,
  input  wire logic rstn,
  input  wire logic i_push,
  input  wire logic i_grant,
  output logic      o_ready,
  output logic      o_req,
  output logic      o_beat_valid,
  output logic      o_done,
  output logic      o_overflow
);

  localparam int c_pend_w = $clog2(MAX_PEND + 1);
  localparam int c_beat_w = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [c_pend_w-1:0] c_pend_max  = c_pend_w'(MAX_PEND);
  localparam logic [c_pend_w-1:0] c_pend_one  = c_pend_w'(1);
  localparam logic [c_beat_w-1:0] c_beat_last = c_beat_w'(BURST_LEN - 1);
  localparam logic [c_beat_w-1:0] c_beat_one  = c_beat_w'(1);

  client_state_t       r_state;
  client_state_t       w_state_nxt;
  logic [c_pend_w-1:0] r_pend;
  logic [c_pend_w-1:0] w_pend_nxt;
  logic [c_beat_w-1:0] r_beat;
  logic [c_beat_w-1:0] w_beat_nxt;
  logic                w_last;
  logic                w_ready;
  logic                w_accept;
  logic                w_has_work;

  assign w_last     = (r_state == ST_OWN) && (r_beat == c_beat_last);
  // A completing job frees its slot in the same cycle, so a full queue can
  // still take a push while its last beat is on the bus.
  assign w_ready    = (r_pend != c_pend_max) || w_last;
  assign w_accept   = i_push && w_ready;
  assign w_has_work = (r_pend != '0);

  always_comb begin
    w_pend_nxt = r_pend;
    case ({w_accept, w_last})
      2'b10:   w_pend_nxt = r_pend + c_pend_one;
      2'b01:   w_pend_nxt = r_pend - c_pend_one;
      default: w_pend_nxt = r_pend;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    case (r_state)
      ST_IDLE: begin
        if (w_has_work) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_grant) begin
          w_state_nxt = ST_OWN;
          w_beat_nxt  = '0;
        end
      end
      ST_OWN: begin
        // Losing the grant before the final beat abandons the tenure; the job
        // stays queued and is retried after the release cycle.
        if (w_last || !i_grant) begin
          w_state_nxt = ST_REL;
          w_beat_nxt  = '0;
        end else begin
          w_beat_nxt = r_beat + c_beat_one;
        end
      end
      ST_REL: begin
        w_state_nxt = w_has_work ? ST_REQ : ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_beat_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_pend  <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  assign o_ready      = w_ready;
  assign o_req        = (r_state == ST_REQ) || (r_state == ST_OWN);
  assign o_beat_valid = (r_state == ST_OWN);
  assign o_done       = w_last;
  assign o_overflow   = i_push && !w_ready;

endmodule
`default_nettype wire

// File: rtl/rr_arb_requester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arb_requester                                                           |
// | N-client requester front end for the round-robin arbiter with grant checks.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rr_arb_requester
  import rr_arb_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int MAX_PEND  = DEF_MAX_PEND,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  wire logic         clk,
  input  wire logic         rstn,
  rr_arb_requester_if.slave bus
);

  logic [N-1:0] w_grant_eff;
  logic [N-1:0] w_req;
  logic [N-1:0] w_ready;
  logic [N-1:0] w_beat_valid;
  logic [N-1:0] w_done;
  logic [N-1:0] w_overflow;
  logic         w_grant_legal;
  logic         w_grant_bad;
  logic         r_err_grant;
  logic         r_err_overflow;

  // A malformed grant vector is discarded entirely rather than partially used.
  assign w_grant_legal = is_onehot0(32'(bus.grant));
  assign w_grant_eff   = w_grant_legal ? bus.grant : '0;
  assign w_grant_bad   = !w_grant_legal || ((bus.grant & ~w_req) != '0);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_client
      rr_arb_client #(
        .MAX_PEND  (MAX_PEND),
        .BURST_LEN (BURST_LEN)
      ) u_client (
        .clk          (clk),
        .rstn         (rstn),
        .i_push       (bus.job_push[gi]),
        .i_grant      (w_grant_eff[gi]),
        .o_ready      (w_ready[gi]),
        .o_req        (w_req[gi]),
        .o_beat_valid (w_beat_valid[gi]),
        .o_done       (w_done[gi]),
        .o_overflow   (w_overflow[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err_grant    <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      if (w_grant_bad) begin
        r_err_grant <= 1'b1;
      end
      if (|w_overflow) begin
        r_err_overflow <= 1'b1;
      end
    end
  end

  assign bus.req          = w_req;
  assign bus.job_ready    = w_ready;
  assign bus.beat_valid   = w_beat_valid;
  assign bus.done         = w_done;
  assign bus.err_grant    = r_err_grant;
  assign bus.err_overflow = r_err_overflow;

endmodule
`default_nettype wire
